// File: rtl/recv_time_module.sv
// Time-sync frame receiver: validates frames, captures first-beat remote/local times, reports offset and counts.
// Result pulses one cycle after the accepted tlast beat; no back-pressure, every valid beat is consumed.
module recv_time_module #(
  parameter int P_FRAME_LEN = 200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_local_time,
  input  logic        i_stat_rx_status,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_time_valid,
  output logic [63:0] o_remote_time,
  output logic [63:0] o_local_cap,
  output logic [63:0] o_time_diff,
  output logic        o_frame_err,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_err_cnt
);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t      state, state_nxt;
  logic [63:0] remote_cap, local_cap, prev;
  logic [63:0] eval_remote, eval_local;
  logic [15:0] beat_cnt, cnt_nxt;
  logic        err, err_nxt;
  logic        accept, keep_bad, eval, good;

  assign accept   = i_rx_axis_tvalid & i_stat_rx_status;
  assign keep_bad = (i_rx_axis_tkeep != 8'hff);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = beat_cnt;
    err_nxt     = err;
    eval        = 1'b0;
    good        = 1'b0;
    eval_remote = remote_cap;
    eval_local  = local_cap;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt     = 16'd1;
          err_nxt     = keep_bad;
          eval_remote = i_rx_axis_tdata;
          eval_local  = i_local_time;
          eval        = i_rx_axis_tlast;
          state_nxt   = i_rx_axis_tlast ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        // Link loss mid-frame drops the frame without any report.
        if (!i_stat_rx_status) begin
          state_nxt = S_IDLE;
        end else if (i_rx_axis_tvalid) begin
          cnt_nxt = (beat_cnt == 16'hffff) ? beat_cnt : beat_cnt + 16'd1;
          err_nxt = err | keep_bad | (i_rx_axis_tdata <= prev);
          eval    = i_rx_axis_tlast;
          if (i_rx_axis_tlast) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    good = eval && (cnt_nxt == 16'(P_FRAME_LEN)) && !err_nxt && !i_rx_axis_tuser;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remote_cap    <= '0;
      local_cap     <= '0;
      prev          <= '0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      o_time_valid  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_remote_time <= '0;
      o_local_cap   <= '0;
      o_time_diff   <= '0;
      o_good_cnt    <= '0;
      o_err_cnt     <= '0;
    end else begin
      o_time_valid <= good;
      o_frame_err  <= eval & ~good;
      beat_cnt     <= cnt_nxt;
      err          <= err_nxt;
      if (accept) prev <= i_rx_axis_tdata;
      // Captures live apart from the result registers so a back-to-back first beat cannot disturb them.
      if (accept && state == S_IDLE) begin
        remote_cap <= i_rx_axis_tdata;
        local_cap  <= i_local_time;
      end
      if (good) begin
        o_remote_time <= eval_remote;
        o_local_cap   <= eval_local;
        o_time_diff   <= eval_local - eval_remote;
        if (o_good_cnt != 32'hffffffff) o_good_cnt <= o_good_cnt + 32'd1;
      end
      if (eval && !good && o_err_cnt != 32'hffffffff) o_err_cnt <= o_err_cnt + 32'd1;
    end
  end

endmodule
